// File: rtl/ntt_butterfly_sched.sv
// Sequencer for the shared butterfly/pointwise compute unit. Drives forward NTT,
// inverse NTT and pointwise passes, plus write-back timed to the unit's pipeline.
module ntt_butterfly_sched #(
   parameter int LOG_N    = 9,
   parameter int PIPE_LAT = 14,
   parameter int FWD_DLY  = 12
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [LOG_N-1:0] rd_addr_a,
   output logic [LOG_N-1:0] rd_addr_b,
   output logic [LOG_N-1:0] tw_addr,
   output logic             forward,
   output logic             reg_forward,
   output logic             forward_delayed,
   output logic             point_mul,
   output logic             wr_en_a,
   output logic             wr_en_b,
   output logic [LOG_N-1:0] wr_addr_a,
   output logic [LOG_N-1:0] wr_addr_b
);

   localparam int LW = $clog2(LOG_N + 1);
   localparam int DW = $clog2(PIPE_LAT + 1);

   localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);
   localparam logic [LOG_N-1:0] HALF_N     = ONE << (LOG_N - 1);
   localparam logic [LOG_N-1:0] HALF_LAST  = HALF_N - ONE;
   localparam logic [LOG_N-1:0] FULL_LAST  = '1;
   localparam logic [LW-1:0]    LAST_LAYER = LW'(LOG_N - 1);
   localparam logic [LW-1:0]    LAYER_ONE  = LW'(1);
   localparam logic [DW-1:0]    DRAIN_LAST = DW'(PIPE_LAT - 1);
   localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);

   localparam logic [1:0] OP_FWD = 2'b00;
   localparam logic [1:0] OP_PW  = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [LOG_N-1:0] k;
   logic [LW-1:0]    layer;
   logic [DW-1:0]    drain_cnt;
   logic [LOG_N-1:0] last_k;
   logic [LW-1:0]    last_layer;

   logic [FWD_DLY-1:0]  fwd_pipe;
   logic [PIPE_LAT-1:0] en_pipe;
   logic [PIPE_LAT-1:0] pw_pipe;
   logic [LOG_N-1:0]    a_pipe [PIPE_LAT];
   logic [LOG_N-1:0]    b_pipe [PIPE_LAT];

   assign last_k     = (op_q == OP_PW) ? FULL_LAST : HALF_LAST;
   assign last_layer = (op_q == OP_PW) ? '0 : LAST_LAYER;

   // Returns {rd_addr_a, rd_addr_b, tw_addr} for beat kk of layer lyr. Forward
   // shrinks the half-span from N/2 down to 1, inverse grows it from 1 up to N/2.
   function automatic logic [3*LOG_N-1:0] issue_addr(input logic [1:0]       mode,
                                                     input logic [LOG_N-1:0] kk,
                                                     input logic [LW-1:0]    lyr);
      logic [LW-1:0]    s;
      logic [LOG_N-1:0] m;
      logic [LOG_N-1:0] grp;
      logic [LOG_N-1:0] j;
      logic [LOG_N-1:0] a;
      if (mode == OP_PW) begin
         return {kk, kk, {LOG_N{1'b0}}};
      end
      s   = (mode == OP_FWD) ? (LAST_LAYER - lyr) : lyr;
      m   = ONE << s;
      grp = kk >> s;
      j   = kk & (m - ONE);
      a   = ((grp << s) << 1) | j;
      return {a, a + m, (HALF_N >> s) + grp};
   endfunction

   // Control FSM; every control output is registered alongside the state.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         op_q      <= '0;
         k         <= '0;
         layer     <= '0;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
         forward   <= 1'b0;
         point_mul <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (op != OP_RSV)) begin
                  op_q      <= op;
                  layer     <= '0;
                  k         <= '0;
                  state     <= RUN;
                  busy      <= 1'b1;
                  forward   <= (op == OP_FWD);
                  point_mul <= (op == OP_PW);
                  rd_en     <= 1'b1;
                  {rd_addr_a, rd_addr_b, tw_addr} <= issue_addr(op, '0, '0);
               end
            end
            RUN: begin
               if (k == last_k) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
                  rd_en     <= 1'b0;
                  rd_addr_a <= '0;
                  rd_addr_b <= '0;
                  tw_addr   <= '0;
               end else begin
                  k <= k + ONE;
                  {rd_addr_a, rd_addr_b, tw_addr} <= issue_addr(op_q, k + ONE, layer);
               end
            end
            DRAIN: begin
               // The last write of this layer lands in the final drain cycle.
               if (drain_cnt == DRAIN_LAST) begin
                  if (layer == last_layer) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     layer <= layer + LAYER_ONE;
                     k     <= '0;
                     state <= RUN;
                     rd_en <= 1'b1;
                     {rd_addr_a, rd_addr_b, tw_addr} <=
                        issue_addr(op_q, '0, layer + LAYER_ONE);
                  end
               end else begin
                  drain_cnt <= drain_cnt + DRAIN_ONE;
               end
            end
            DONE: begin
               state     <= IDLE;
               done      <= 1'b0;
               busy      <= 1'b0;
               forward   <= 1'b0;
               point_mul <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Delay lines that realign mode and write-back with the compute pipeline.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fwd_pipe <= '0;
         en_pipe  <= '0;
         pw_pipe  <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            a_pipe[i] <= '0;
            b_pipe[i] <= '0;
         end
      end else begin
         fwd_pipe <= {fwd_pipe[FWD_DLY-2:0], forward};
         en_pipe  <= {en_pipe[PIPE_LAT-2:0], rd_en};
         pw_pipe  <= {pw_pipe[PIPE_LAT-2:0], rd_en & point_mul};
         a_pipe[0] <= rd_addr_a;
         b_pipe[0] <= rd_addr_b;
         for (int i = 1; i < PIPE_LAT; i++) begin
            a_pipe[i] <= a_pipe[i-1];
            b_pipe[i] <= b_pipe[i-1];
         end
      end
   end

   assign reg_forward     = fwd_pipe[0];
   assign forward_delayed = fwd_pipe[FWD_DLY-1];
   // Pointwise results appear only on out_b, so port a stays quiet.
   assign wr_en_a   = en_pipe[PIPE_LAT-1] & ~pw_pipe[PIPE_LAT-1];
   assign wr_en_b   = en_pipe[PIPE_LAT-1];
   assign wr_addr_a = a_pipe[PIPE_LAT-1];
   assign wr_addr_b = b_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_butterfly_sched.sv
// Scoreboard bench for ntt_butterfly_sched at N=8: hand tables of expected issues
// and write-backs are queued at start, a negedge monitor pops and compares.
module tb_ntt_butterfly_sched;

   localparam int LOG_N    = 3;
   localparam int PIPE_LAT = 14;
   localparam int FWD_DLY  = 12;

   logic       clk;
   logic       resetn;
   logic       start;
   logic [1:0] op;
   logic       busy;
   logic       done;
   logic       rd_en;
   logic [2:0] rd_addr_a;
   logic [2:0] rd_addr_b;
   logic [2:0] tw_addr;
   logic       forward;
   logic       reg_forward;
   logic       forward_delayed;
   logic       point_mul;
   logic       wr_en_a;
   logic       wr_en_b;
   logic [2:0] wr_addr_a;
   logic [2:0] wr_addr_b;

   ntt_butterfly_sched #(
      .LOG_N   (LOG_N),
      .PIPE_LAT(PIPE_LAT),
      .FWD_DLY (FWD_DLY)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .start          (start),
      .op             (op),
      .busy           (busy),
      .done           (done),
      .rd_en          (rd_en),
      .rd_addr_a      (rd_addr_a),
      .rd_addr_b      (rd_addr_b),
      .tw_addr        (tw_addr),
      .forward        (forward),
      .reg_forward    (reg_forward),
      .forward_delayed(forward_delayed),
      .point_mul      (point_mul),
      .wr_en_a        (wr_en_a),
      .wr_en_b        (wr_en_b),
      .wr_addr_a      (wr_addr_a),
      .wr_addr_b      (wr_addr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         off;
      logic [8:0] addr;
      logic       fwd;
      logic       pm;
   } iss_t;

   typedef struct {
      int         off;
      logic       ea;
      logic       eb;
      logic [5:0] addr;
      logic       fwd;
   } wr_t;

   iss_t iss_q[$];
   wr_t  wr_q[$];
   int   done_q[$];
   int   len_q[$];

   int   t0 = 0;
   bit   mon_en = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;
   logic busy_prev = 1'b0;
   int   busy_start = 0;
   iss_t mi;
   wr_t  mw;

   // Forward order, octal digits {a, b, tw}; inverse walks the layers backwards.
   localparam logic [8:0] FWD_TAB [12] = '{
      9'o041, 9'o151, 9'o261, 9'o371,
      9'o022, 9'o132, 9'o463, 9'o573,
      9'o014, 9'o235, 9'o456, 9'o677
   };

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
   endtask

   task automatic wait_off(input int n);
      while (cyc - t0 < n) @(negedge clk);
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, forward, reg_forward,
                  forward_delayed, point_mul, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b});
   endfunction

   task automatic apply_stimulus(input logic [1:0] code, input bit poke);
      int         layers;
      int         beats;
      int         len;
      bit         f;
      logic [8:0] v;
      iss_t       it;
      wr_t        w;
      layers = (code == 2'b10) ? 1 : 3;
      beats  = (code == 2'b10) ? 8 : 4;
      len    = layers * (beats + PIPE_LAT) + 1;
      f      = (code == 2'b00);
      for (int l = 0; l < layers; l++) begin
         for (int k = 0; k < beats; k++) begin
            if (code == 2'b10)      v = {3'(k), 3'(k), 3'd0};
            else if (code == 2'b00) v = FWD_TAB[l*4 + k];
            else                    v = FWD_TAB[(2 - l)*4 + k];
            it.off  = l * (beats + PIPE_LAT) + k;
            it.addr = v;
            it.fwd  = f;
            it.pm   = (code == 2'b10);
            iss_q.push_back(it);
            w.off  = it.off + PIPE_LAT;
            w.ea   = (code != 2'b10);
            w.eb   = 1'b1;
            w.addr = v[8:3];
            w.fwd  = f;
            wr_q.push_back(w);
         end
      end
      done_q.push_back(len - 1);
      len_q.push_back(len);
      @(negedge clk);
      op    = code;
      start = 1'b1;
      t0    = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      if (poke) begin
         wait_off(2);
         start = 1'b1;
         op    = 2'b01;
         @(negedge clk);
         start = 1'b0;
         op    = code;
      end
      wait_off(FWD_DLY - 1);
      check_output("fwd_dly_before", 32'(forward_delayed), 32'(0));
      wait_off(FWD_DLY);
      check_output("fwd_dly_rise", 32'(forward_delayed), 32'(f));
      wait_off(len + FWD_DLY - 1);
      check_output("fwd_dly_tail", 32'(forward_delayed), 32'(f));
      wait_off(len + FWD_DLY);
      check_output("fwd_dly_clear", 32'(forward_delayed), 32'(0));
   endtask

   // Monitor: pops expected issues, writes, done pulses and busy lengths.
   always @(negedge clk) begin
      if (mon_en && resetn) begin
         if (rd_en) begin
            if (iss_q.size() == 0) check_output("unexpected_issue", 32'(rd_en), 32'(0));
            else begin
               mi = iss_q.pop_front();
               check_output("issue_off", cyc - t0, mi.off);
               check_output("issue_data",
                            32'({rd_addr_a, rd_addr_b, tw_addr, forward, point_mul}),
                            32'({mi.addr, mi.fwd, mi.pm}));
            end
         end
         if (wr_en_a || wr_en_b) begin
            if (wr_q.size() == 0) check_output("unexpected_write", 32'({wr_en_a, wr_en_b}), 32'(0));
            else begin
               mw = wr_q.pop_front();
               check_output("write_off", cyc - t0, mw.off);
               check_output("write_data",
                            32'({wr_en_a, wr_en_b, wr_addr_a, wr_addr_b, reg_forward, forward_delayed}),
                            32'({mw.ea, mw.eb, mw.addr, mw.fwd, mw.fwd}));
            end
         end
         if (done) begin
            if (done_q.size() == 0) check_output("unexpected_done", 32'(done), 32'(0));
            else check_output("done_off", cyc - t0, done_q.pop_front());
         end
         if (busy && !busy_prev) busy_start = cyc;
         if (!busy && busy_prev) begin
            if (len_q.size() == 0) check_output("unexpected_busy", 32'(cyc - busy_start), 32'(0));
            else check_output("busy_len", cyc - busy_start, len_q.pop_front());
         end
      end
      busy_prev = busy;
   end

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      op     = 2'b00;
      repeat (3) @(negedge clk);
      check_output("reset_state", all_outputs(), 32'(0));
      resetn = 1'b1;
      @(negedge clk);

      apply_stimulus(2'b00, 1'b0);
      apply_stimulus(2'b01, 1'b0);
      apply_stimulus(2'b10, 1'b0);
      apply_stimulus(2'b00, 1'b1);

      // Reserved op must not start anything.
      @(negedge clk);
      op    = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op    = 2'b00;
      for (int i = 0; i < 3; i++) begin
         check_output("op11_idle", 32'({busy, done, rd_en}), 32'(0));
         @(negedge clk);
      end

      // Abort a forward transform in layer 1, then run a clean one.
      mon_en = 1'b0;
      op     = 2'b00;
      start  = 1'b1;
      t0     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      wait_off(20);
      check_output("abort_running", 32'({busy, rd_en}), 32'(3));
      #1 resetn = 1'b0;
      #1 check_output("abort_outputs", all_outputs(), 32'(0));
      @(negedge clk);
      check_output("abort_held", all_outputs(), 32'(0));
      resetn = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      apply_stimulus(2'b00, 1'b0);

      check_output("issue_q_empty", iss_q.size(), 0);
      check_output("write_q_empty", wr_q.size(), 0);
      check_output("done_q_empty", done_q.size() + len_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
